// File: rtl/fft_peak_tracker.sv
// fft_peak_tracker: per-frame top-N peak tracker with in-window energy and loudness flag.
// Results are registered at frame end and held on a ready/valid output.
module fft_peak_tracker #(
    parameter int NSamples    = 1024,
    parameter int W           = 33,
    parameter int NPeaks      = 3,
    parameter int BitReversed = 1,
    parameter int NBits       = $clog2(NSamples),
    parameter int EW          = W + NBits
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [W-1:0]                  mag,
    input  logic                          mag_valid,
    input  logic [NBits-1:0]              k_lo,
    input  logic [NBits-1:0]              k_hi,
    input  logic [EW-1:0]                 loud_thresh,
    output logic [NPeaks*W-1:0]           peak,
    output logic [NPeaks*NBits-1:0]       peak_k,
    output logic [$clog2(NPeaks+1)-1:0]   peak_count,
    output logic [EW-1:0]                 energy,
    output logic                          loud,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overrun
);
    localparam int CW = $clog2(NPeaks+1);
    logic [NBits-1:0] i, k, kr, k_lo_r, k_hi_r, lo, hi, pk;
    logic [NPeaks-1:0][W-1:0] sm, nm;
    logic [NPeaks-1:0][NBits-1:0] sk, nk;
    logic [W-1:0] pm;
    logic [EW-1:0] e, ne;
    logic [CW-1:0] cnt;
    logic q, last, g, pg;

    // The window for sample 0 comes straight from the ports, since it is captured on that same edge.
    always_comb begin
        for (int b = 0; b < NBits; b++) kr[b] = i[NBits-1-b];
        k = (BitReversed != 0) ? kr : i;
        lo = (i == '0) ? k_lo : k_lo_r;
        hi = (i == '0) ? k_hi : k_hi_r;
        q = mag_valid && k >= lo && k <= hi;
        ne = e + (q ? EW'(mag) : '0);
        last = mag_valid && i == NBits'(NSamples - 1);
        pg = 1'b0;
        pm = mag;
        pk = k;
        g = 1'b0;
        cnt = '0;
        for (int j = 0; j < NPeaks; j++) begin
            g = q && mag > sm[j];
            nm[j] = !g ? sm[j] : pg ? pm : mag;
            nk[j] = !g ? sk[j] : pg ? pk : k;
            pg = g;
            pm = sm[j];
            pk = sk[j];
            cnt = cnt + CW'(nm[j] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i <= '0;
            k_lo_r <= '0;
            k_hi_r <= '0;
            sm <= '0;
            sk <= '0;
            e <= '0;
            peak <= '0;
            peak_k <= '0;
            peak_count <= '0;
            energy <= '0;
            loud <= 1'b0;
            out_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= last && out_valid && !out_ready;
            if (mag_valid) begin
                i <= i + 1'b1;
                if (i == '0) begin
                    k_lo_r <= k_lo;
                    k_hi_r <= k_hi;
                end
                sm <= last ? '0 : nm;
                sk <= last ? '0 : nk;
                e <= last ? '0 : ne;
            end
            if (last) begin
                peak <= nm;
                peak_k <= nk;
                peak_count <= cnt;
                energy <= ne;
                loud <= ne >= loud_thresh;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fft_peak_tracker.sv
// tb_fft_peak_tracker: directed frames on natural- and bit-reversed-order instances,
// expected results from a selection-sort reference queued per frame.
module tb_fft_peak_tracker;
    localparam int NS = 16, W = 16, NP = 3, NB = 4, EW = 20;

    typedef struct packed {
        logic [NP*W-1:0]  pk;
        logic [NP*NB-1:0] kk;
        logic [1:0]       cnt;
        logic [EW-1:0]    e;
        logic             loud;
    } exp_t;

    logic clk = 0, reset, mag_valid, out_ready;
    logic [W-1:0] mag;
    logic [NB-1:0] k_lo, k_hi;
    logic [EW-1:0] loud_thresh;
    logic [NP*W-1:0] pk0, pk1;
    logic [NP*NB-1:0] kk0, kk1;
    logic [1:0] c0, c1;
    logic [EW-1:0] en0, en1;
    logic ld0, ld1, v0, v1, ov0, ov1;
    logic [W-1:0] m [NS];
    exp_t q0[$], q1[$];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    fft_peak_tracker #(.NSamples(NS), .W(W), .NPeaks(NP), .BitReversed(0)) u0 (
        .clk(clk), .reset(reset), .mag(mag), .mag_valid(mag_valid), .k_lo(k_lo), .k_hi(k_hi),
        .loud_thresh(loud_thresh), .peak(pk0), .peak_k(kk0), .peak_count(c0), .energy(en0),
        .loud(ld0), .out_valid(v0), .out_ready(out_ready), .overrun(ov0));

    fft_peak_tracker #(.NSamples(NS), .W(W), .NPeaks(NP), .BitReversed(1)) u1 (
        .clk(clk), .reset(reset), .mag(mag), .mag_valid(mag_valid), .k_lo(k_lo), .k_hi(k_hi),
        .loud_thresh(loud_thresh), .peak(pk1), .peak_k(kk1), .peak_count(c1), .energy(en1),
        .loud(ld1), .out_valid(v1), .out_ready(out_ready), .overrun(ov1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] kof(input int n, input bit br);
        logic [NB-1:0] a;
        a = n[NB-1:0];
        return br ? {a[0], a[1], a[2], a[3]} : a;
    endfunction

    // Reference: pick the largest remaining qualifying bin per slot, earliest arrival on ties.
    function automatic exp_t model(input int lo, input int hi, input logic [EW-1:0] th, input bit br);
        exp_t x;
        bit taken [NS];
        int best;
        x = '0;
        for (int n = 0; n < NS; n++) begin
            taken[n] = 0;
            if (int'(kof(n, br)) >= lo && int'(kof(n, br)) <= hi) x.e = x.e + EW'(m[n]);
        end
        for (int s = 0; s < NP; s++) begin
            best = -1;
            for (int n = 0; n < NS; n++)
                if (int'(kof(n, br)) >= lo && int'(kof(n, br)) <= hi && !taken[n] && m[n] != 0 &&
                    (best < 0 || m[n] > m[best])) best = n;
            if (best >= 0) begin
                taken[best] = 1;
                x.pk[s*W +: W] = m[best];
                x.kk[s*NB +: NB] = kof(best, br);
                x.cnt = x.cnt + 2'd1;
            end
        end
        x.loud = x.e >= th;
        return x;
    endfunction

    task automatic pop_chk();
        exp_t a, b;
        a = q0.pop_front();
        b = q1.pop_front();
        chk("peak_nat", 64'(pk0), 64'(a.pk));
        chk("peak_k_nat", 64'(kk0), 64'(a.kk));
        chk("count_nat", 64'(c0), 64'(a.cnt));
        chk("energy_nat", 64'(en0), 64'(a.e));
        chk("loud_nat", 64'(ld0), 64'(a.loud));
        chk("peak_br", 64'(pk1), 64'(b.pk));
        chk("peak_k_br", 64'(kk1), 64'(b.kk));
        chk("count_br", 64'(c1), 64'(b.cnt));
        chk("energy_br", 64'(en1), 64'(b.e));
        chk("loud_br", 64'(ld1), 64'(b.loud));
    endtask

    task automatic frame(input int lo, input int hi, input logic [EW-1:0] th, input int maxgap);
        k_lo = NB'(lo);
        k_hi = NB'(hi);
        loud_thresh = th;
        q0.push_back(model(lo, hi, th, 0));
        q1.push_back(model(lo, hi, th, 1));
        for (int n = 0; n < NS; n++) begin
            repeat ($urandom_range(0, maxgap)) begin
                mag_valid = 0;
                mag = W'($urandom);
                tick();
            end
            if (n == NS - 1 && out_ready) chk("idle_before_last", 64'(v0), 64'(0));
            mag = m[n];
            mag_valid = 1;
            tick();
        end
        mag_valid = 0;
        chk("valid_after_last_nat", 64'(v0), 64'(1));
        chk("valid_after_last_br", 64'(v1), 64'(1));
        pop_chk();
    endtask

    initial begin
        reset = 1;
        mag_valid = 0;
        mag = '0;
        out_ready = 1;
        k_lo = '0;
        k_hi = '0;
        loud_thresh = '0;
        tick();
        tick();
        chk("rst_valid", 64'(v0), 64'(0));
        chk("rst_count", 64'(c0), 64'(0));
        chk("rst_energy", 64'(en0), 64'(0));
        chk("rst_loud", 64'(ld0), 64'(0));
        chk("rst_overrun", 64'(ov0), 64'(0));
        chk("rst_peak", 64'(pk1), 64'(0));
        reset = 0;

        for (int n = 0; n < NS; n++) m[n] = W'(n * 10);
        frame(0, 15, 0, 0);
        chk("ramp_energy_lit", 64'(en0), 64'(1200));
        chk("ramp_peak_lit", 64'(pk0), {16'h0, 16'd130, 16'd140, 16'd150});
        chk("ramp_k_lit", 64'(kk0), 64'({4'd13, 4'd14, 4'd15}));
        tick();
        chk("valid_drop", 64'(v0), 64'(0));

        for (int n = 0; n < NS; n++) m[n] = 100;
        frame(4, 6, 300, 0);
        chk("tie_k_lit", 64'(kk0), 64'({4'd6, 4'd5, 4'd4}));
        chk("thresh_eq_loud", 64'(ld0), 64'(1));
        frame(4, 6, 301, 0);
        chk("thresh_above_quiet", 64'(ld0), 64'(0));

        for (int n = 0; n < NS; n++) m[n] = 0;
        m[1] = 77;
        frame(0, 15, 0, 0);
        chk("br_k_lit", 64'(kk1), 64'(12'h008));
        chk("br_count_lit", 64'(c1), 64'(1));

        for (int n = 0; n < NS; n++) m[n] = W'(n * 10);
        frame(0, 15, 1200, 3);

        tick();
        out_ready = 0;
        for (int n = 0; n < NS; n++) m[n] = W'($urandom_range(0, 1000));
        frame(0, 15, 5000, 0);
        chk("no_overrun_first", 64'(ov0), 64'(0));
        for (int n = 0; n < NS; n++) m[n] = W'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 60000));
        frame(2, 12, 100000, 0);
        chk("overrun_pulse", 64'(ov0), 64'(1));
        chk("overrun_valid", 64'(v0), 64'(1));
        tick();
        chk("overrun_single", 64'(ov0), 64'(0));
        chk("valid_held", 64'(v0), 64'(1));
        out_ready = 1;
        tick();
        chk("valid_drop_ready", 64'(v0), 64'(0));

        for (int n = 0; n < 7; n++) begin
            mag = 60000;
            mag_valid = 1;
            tick();
        end
        mag_valid = 0;
        reset = 1;
        tick();
        reset = 0;
        chk("midrst_energy", 64'(en0), 64'(0));
        chk("midrst_valid", 64'(v0), 64'(0));
        for (int n = 0; n < NS; n++) m[n] = W'(n * 7 + 3);
        frame(0, 15, 0, 1);

        frame(10, 5, 1, 0);
        chk("empty_count", 64'(c0), 64'(0));
        chk("empty_energy", 64'(en0), 64'(0));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
